// File: rtl/mem_stage_pkg.sv
// Shared types and operation decode for the memory stage.
package mem_stage_pkg;

  // Operation class decoded from the EX/MEM control bits.
  typedef enum logic [2:0] {
    NONE    = 3'd0,
    LOAD    = 3'd1,
    STORE   = 3'd2,
    PUSH    = 3'd3,
    POP     = 3'd4,
    ILLEGAL = 3'd5
  } op_class_e;

  // Memory-stage sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Map raw control bits to an operation class. Contradictory combinations
  // (push with pop, read with write, push/pop without their matching access)
  // are classed ILLEGAL so the stage can drop them without touching memory.
  function automatic op_class_e decode_op(input logic i_mem_read,
                                          input logic i_mem_write,
                                          input logic i_push,
                                          input logic i_pop);
    op_class_e cls;
    cls = NONE;
    if ((i_push && i_pop) || (i_mem_read && i_mem_write) ||
        (i_push && !i_mem_write) || (i_pop && !i_mem_read)) begin
      cls = ILLEGAL;
    end else if (i_push) begin
      cls = PUSH;
    end else if (i_pop) begin
      cls = POP;
    end else if (i_mem_read) begin
      cls = LOAD;
    end else if (i_mem_write) begin
      cls = STORE;
    end
    return cls;
  endfunction

  // True for classes that need a data-memory access.
  function automatic logic is_mem_op(input op_class_e cls);
    return (cls == LOAD) || (cls == STORE) || (cls == PUSH) || (cls == POP);
  endfunction

endpackage

// File: rtl/mem_stage_pipe_stack_ptr.sv
// Stack pointer register: resets to SP_INIT, steps by one with silent wrap.
module stack_ptr #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [ADDR_W-1:0] o_sp
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_sp;

  // Pointer update: pop increments, push decrements, modulo 2**ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= SP_INIT;
    end else if (i_inc) begin
      r_sp <= r_sp + ONE;
    end else if (i_dec) begin
      r_sp <= r_sp - ONE;
    end
  end

  assign o_sp = r_sp;

endmodule

// File: rtl/mem_stage_pipe.sv
// Memory stage between EX/MEM and MEM/WB: decodes load/store/push/pop,
// runs them through a variable-latency req/ack port, owns the stack pointer
// and registers the MEM/WB buffer with an already-selected writeback value.
//
// Memory handshake: mem_req rises in the first BUSY cycle and stays high with
// mem_addr/mem_we/mem_wdata stable until a cycle in which mem_ack=1; that
// cycle completes the access (mem_rdata is sampled there) and mem_req drops
// the next cycle. mem_ack is only looked at while BUSY. Upstream, stall=1
// means the EX/MEM buffer must hold its instruction.
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 32,
  parameter int                REG_AW  = 3,
  parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rsrc_value,
  input  logic [DATA_W-1:0] rdst_value,
  input  logic [REG_AW-1:0] rdst_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              push,
  input  logic              pop,
  input  logic              wb,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] sp,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_rdst_addr,
  output logic              wb_en,
  output logic              op_err,
  output state_e            dbg_state
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Sequencer state
  state_e            r_state;
  state_e            w_state_nxt;

  // Access latched at accept time, held through BUSY and beyond
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [REG_AW-1:0] r_rdst;
  logic              r_wb;
  logic [DATA_W-1:0] r_alu;
  op_class_e         r_cls;

  // MEM/WB buffer
  logic              r_wb_valid;
  logic [DATA_W-1:0] r_wb_data;
  logic [REG_AW-1:0] r_wb_rdst;
  logic              r_wb_en;
  logic              r_op_err;

  // Decode and helpers
  op_class_e         w_cls;
  logic              w_is_mem;
  logic              w_accept_mem;
  logic              w_accept_alu;
  logic              w_ack;
  logic [ADDR_W-1:0] w_sp;
  logic [ADDR_W-1:0] w_addr_sel;

  assign w_cls        = decode_op(mem_read, mem_write, push, pop);
  assign w_is_mem     = is_mem_op(w_cls);
  assign w_accept_mem = (r_state == IDLE) && in_valid && w_is_mem;
  assign w_accept_alu = (r_state == IDLE) && in_valid && !w_is_mem;
  assign w_ack        = (r_state == BUSY) && mem_ack;

  // Stack pointer: only acknowledged pushes and pops move it.
  stack_ptr #(
    .ADDR_W  (ADDR_W),
    .SP_INIT (SP_INIT)
  ) u_stack_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_ack && (r_cls == POP)),
    .i_dec (w_ack && (r_cls == PUSH)),
    .o_sp  (w_sp)
  );

  // Address mux: operands are zero-extended; push writes at sp, pop reads sp+1.
  always_comb begin
    w_addr_sel = r_addr;
    case (w_cls)
      LOAD:    w_addr_sel = ADDR_W'(rsrc_value);
      STORE:   w_addr_sel = ADDR_W'(rdst_value);
      PUSH:    w_addr_sel = w_sp;
      POP:     w_addr_sel = w_sp + ONE;
      default: w_addr_sel = r_addr;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, stall and request. Stall covers the accept cycle and every
  // BUSY cycle still waiting for ack.
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    mem_req     = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && w_is_mem) begin
          stall       = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        mem_req = 1'b1;
        stall   = !mem_ack;
        if (mem_ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the access on accept; values persist after the access completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rdst  <= '0;
      r_wb    <= 1'b0;
      r_alu   <= '0;
      r_cls   <= NONE;
    end else if (w_accept_mem) begin
      r_addr  <= w_addr_sel;
      r_wdata <= rsrc_value;
      r_we    <= (w_cls == STORE) || (w_cls == PUSH);
      r_rdst  <= rdst_addr;
      r_wb    <= wb;
      r_alu   <= alu_result;
      r_cls   <= w_cls;
    end
  end

  // MEM/WB buffer: payload updates only when a result retires, so it holds
  // its last value under wb_valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_rdst  <= '0;
      r_wb_en    <= 1'b0;
      r_op_err   <= 1'b0;
    end else begin
      r_op_err   <= 1'b0;
      r_wb_valid <= 1'b0;
      if (w_accept_alu) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= alu_result;
        r_wb_rdst  <= rdst_addr;
        r_wb_en    <= wb && (w_cls != ILLEGAL);
        r_op_err   <= (w_cls == ILLEGAL);
      end else if (w_ack) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= ((r_cls == LOAD) || (r_cls == POP)) ? mem_rdata : r_alu;
        r_wb_rdst  <= r_rdst;
        r_wb_en    <= r_wb;
      end
    end
  end

  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign sp           = w_sp;
  assign wb_valid     = r_wb_valid;
  assign wb_data      = r_wb_data;
  assign wb_rdst_addr = r_wb_rdst;
  assign wb_en        = r_wb_en;
  assign op_err       = r_op_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: a transaction-level model (expected
// request and writeback queues plus a model stack pointer) checked every
// cycle, with literal expectations pinning key results.
module tb_mem_stage_pipe;
  import mem_stage_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 32;
  localparam int REG_AW = 3;

  // Control encodings {push, pop, mem_read, mem_write}
  localparam logic [3:0] C_NONE  = 4'b0000;
  localparam logic [3:0] C_LOAD  = 4'b0010;
  localparam logic [3:0] C_STORE = 4'b0001;
  localparam logic [3:0] C_PUSH  = 4'b1001;
  localparam logic [3:0] C_POP   = 4'b0110;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid = 0;
  logic [DATA_W-1:0] alu_result = '0, rsrc_value = '0, rdst_value = '0;
  logic [REG_AW-1:0] rdst_addr = '0;
  logic              mem_read = 0, mem_write = 0, push = 0, pop = 0, wb = 0;
  logic              stall, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr, sp;
  logic [DATA_W-1:0] mem_wdata, wb_data;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 0;
  logic              wb_valid, wb_en, op_err;
  logic [REG_AW-1:0] wb_rdst_addr;
  state_e            dbg_state;

  mem_stage_pipe #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .REG_AW (REG_AW), .SP_INIT ('1)
  ) dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid),
    .alu_result (alu_result), .rsrc_value (rsrc_value), .rdst_value (rdst_value),
    .rdst_addr (rdst_addr), .mem_read (mem_read), .mem_write (mem_write),
    .push (push), .pop (pop), .wb (wb), .stall (stall), .mem_req (mem_req),
    .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata), .mem_ack (mem_ack), .sp (sp), .wb_valid (wb_valid),
    .wb_data (wb_data), .wb_rdst_addr (wb_rdst_addr), .wb_en (wb_en),
    .op_err (op_err), .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] rd;
    logic              en;
    logic              err;
  } wb_exp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } req_exp_t;

  wb_exp_t           exp_q[$];
  req_exp_t          req_q[$];
  logic [ADDR_W-1:0] m_sp;
  logic              mon_en = 0;
  int                cyc = 0;
  int                n_vec = 0;
  int                n_err = 0;
  int                last_stall = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_wdata = '0;
  logic              last_we = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("sp", sp, m_sp);
      if (mem_req) begin
        n_vec++;
        if (req_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_req: mem_req=1 addr=0x%0h with no access pending", mem_addr);
        end else begin
          check("mem_addr", mem_addr, req_q[0].addr);
          check("mem_we", mem_we, req_q[0].we);
          if (req_q[0].we) check("mem_wdata", mem_wdata, req_q[0].wdata);
          last_addr  = mem_addr;
          last_wdata = mem_wdata;
          last_we    = mem_we;
          if (mem_ack) void'(req_q.pop_front());
        end
      end
      if (wb_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_wb: wb_valid=1 data=0x%0h with nothing expected", wb_data);
        end else begin
          wb_exp_t e;
          e = exp_q.pop_front();
          check("wb_cycle", cyc, e.due);
          check("wb_data", wb_data, e.data);
          check("wb_rdst_addr", wb_rdst_addr, e.rd);
          check("wb_en", wb_en, e.en);
          check("op_err", op_err, e.err);
        end
      end else begin
        check("op_err_no_wb", op_err, 1'b0);
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          n_vec++;
          n_err++;
          $display("FAIL wb_missing: wb_valid=0, expected writeback data=0x%0h due cycle %0d",
                   exp_q[0].data, exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic op_class_e ref_class(input logic [3:0] ctl);
    case (ctl)
      C_NONE:  return NONE;
      C_LOAD:  return LOAD;
      C_STORE: return STORE;
      C_PUSH:  return PUSH;
      C_POP:   return POP;
      default: return ILLEGAL;
    endcase
  endfunction

  task automatic go_idle();
    @(posedge clk); #1;
    in_valid = 0; mem_ack = 0;
    {push, pop, mem_read, mem_write} = C_NONE;
  endtask

  // One instruction; memory ops are acked after wait_n BUSY cycles.
  task automatic do_op(input logic [3:0] ctl, input logic wbb, input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] rsrc, input logic [DATA_W-1:0] rdst,
                       input logic [REG_AW-1:0] ra, input int wait_n,
                       input logic [DATA_W-1:0] rdata);
    op_class_e c;
    req_exp_t  r;
    wb_exp_t   e;
    c = ref_class(ctl);
    @(posedge clk); #1;
    in_valid = 1; {push, pop, mem_read, mem_write} = ctl; wb = wbb;
    alu_result = alu; rsrc_value = rsrc; rdst_value = rdst; rdst_addr = ra; mem_ack = 0;
    if (c == NONE || c == ILLEGAL) begin
      @(negedge clk);
      check("stall_alu", stall, 1'b0);
      e = '{due: cyc + 1, data: alu, rd: ra, en: wbb && (c != ILLEGAL), err: (c == ILLEGAL)};
      exp_q.push_back(e);
    end else begin
      r.we    = (c == STORE) || (c == PUSH);
      r.wdata = rsrc;
      case (c)
        LOAD:    r.addr = {{(ADDR_W-DATA_W){1'b0}}, rsrc};
        STORE:   r.addr = {{(ADDR_W-DATA_W){1'b0}}, rdst};
        PUSH:    r.addr = m_sp;
        default: r.addr = m_sp + 32'd1;
      endcase
      req_q.push_back(r);
      last_stall = 0;
      @(negedge clk);
      if (stall) last_stall++;
      for (int i = 0; i < wait_n; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (stall) last_stall++;
      end
      @(posedge clk); #1;
      mem_ack = 1; mem_rdata = rdata;
      @(negedge clk);
      check("stall_ack", stall, 1'b0);
      e = '{due: cyc + 1, data: (c == LOAD || c == POP) ? rdata : alu, rd: ra, en: wbb, err: 1'b0};
      exp_q.push_back(e);
      @(posedge clk); #1;
      mem_ack = 0; in_valid = 0; {push, pop, mem_read, mem_write} = C_NONE;
      if (c == PUSH) m_sp = m_sp - 32'd1;
      if (c == POP)  m_sp = m_sp + 32'd1;
      check("stall_cycles", last_stall, wait_n + 1);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] illegal_tbl[4];

  initial begin
    illegal_tbl[0] = 4'b1100; // push & pop
    illegal_tbl[1] = 4'b0011; // mem_read & mem_write
    illegal_tbl[2] = 4'b1000; // push without mem_write
    illegal_tbl[3] = 4'b0100; // pop without mem_read

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sp", sp, 32'hFFFF_FFFF);
    check("rst_stall", stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_data", wb_data, 16'h0);
    check("rst_wb_rdst", wb_rdst_addr, 3'd0);
    check("rst_wb_en", wb_en, 1'b0);
    check("rst_op_err", op_err, 1'b0);
    check("rst_state", dbg_state, IDLE);
    rst_n  = 1;
    m_sp   = 32'hFFFF_FFFF;
    mon_en = 1;

    // PUSH 0x1234, ack in first BUSY cycle
    do_op(C_PUSH, 1'b0, 16'h0077, 16'h1234, 16'h0, 3'd2, 0, 16'h0);
    check("push_addr", last_addr, 32'hFFFF_FFFF);
    check("push_wdata", last_wdata, 16'h1234);
    check("push_we", last_we, 1'b1);
    @(negedge clk);
    check("push_sp", sp, 32'hFFFF_FFFE);
    check("push_wb_valid", wb_valid, 1'b1);
    check("push_wb_en", wb_en, 1'b0);

    // POP with 3 stall cycles
    do_op(C_POP, 1'b1, 16'h0, 16'h0, 16'h0, 3'd5, 2, 16'h1234);
    check("pop_addr", last_addr, 32'hFFFF_FFFF);
    check("pop_stall3", last_stall, 3);
    @(negedge clk);
    check("pop_sp", sp, 32'hFFFF_FFFF);
    check("pop_wb_data", wb_data, 16'h1234);
    check("pop_wb_rdst", wb_rdst_addr, 3'd5);
    check("pop_wb_en", wb_en, 1'b1);

    // LOAD then STORE
    do_op(C_LOAD, 1'b1, 16'h1111, 16'h0040, 16'h0, 3'd3, 1, 16'hCAFE);
    check("load_addr", last_addr, 32'h0000_0040);
    @(negedge clk);
    check("load_wb_data", wb_data, 16'hCAFE);
    do_op(C_STORE, 1'b0, 16'h5555, 16'hBEEF, 16'h0080, 3'd4, 0, 16'h0);
    check("store_addr", last_addr, 32'h0000_0080);
    check("store_we", last_we, 1'b1);
    check("store_wdata", last_wdata, 16'hBEEF);

    // Back-to-back NONE ops
    for (int i = 1; i <= 3; i++)
      do_op(C_NONE, 1'b1, 16'(i), 16'h0, 16'h0, 3'(i), 0, 16'h0);
    go_idle();
    @(negedge clk);

    // Illegal combinations
    for (int i = 0; i < 4; i++) begin
      do_op(illegal_tbl[i], 1'b1, 16'h0099 + 16'(i), 16'h0, 16'h0, 3'd6, 0, 16'h0);
      go_idle();
      @(negedge clk);
      check("illegal_op_err", op_err, 1'b1);
      check("illegal_wb_en", wb_en, 1'b0);
      @(negedge clk);
      check("illegal_pulse_end", op_err, 1'b0);
    end

    // Wrap: POP from max reads address 0 and wraps sp to 0; PUSH wraps back.
    do_op(C_POP, 1'b1, 16'h0, 16'h0, 16'h0, 3'd1, 0, 16'hA5A5);
    check("wrap_pop_addr", last_addr, 32'h0);
    @(negedge clk);
    check("wrap_pop_sp", sp, 32'h0);
    do_op(C_PUSH, 1'b0, 16'h0, 16'h7777, 16'h0, 3'd1, 1, 16'h0);
    check("wrap_push_addr", last_addr, 32'h0);
    @(negedge clk);
    check("wrap_push_sp", sp, 32'hFFFF_FFFF);

    // Move sp off its reset value, then reset in the middle of BUSY.
    do_op(C_PUSH, 1'b0, 16'h0, 16'h0101, 16'h0, 3'd0, 0, 16'h0);
    @(posedge clk); #1;
    in_valid = 1; {push, pop, mem_read, mem_write} = C_PUSH; rsrc_value = 16'h4321;
    req_q.push_back('{addr: m_sp, we: 1'b1, wdata: 16'h4321});
    @(posedge clk); #1;
    @(negedge clk);
    check("midbusy_req", mem_req, 1'b1);
    #1;
    mon_en = 0;
    rst_n  = 0;
    in_valid = 0; {push, pop, mem_read, mem_write} = C_NONE;
    req_q.delete();
    exp_q.delete();
    #1;
    check("inrst_req", mem_req, 1'b0);
    check("inrst_sp", sp, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    rst_n = 1;
    mem_ack = 1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    check("late_ack_state", dbg_state, IDLE);
    check("late_ack_req", mem_req, 1'b0);
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    check("late_ack_wb_valid", wb_valid, 1'b0);
    check("late_ack_sp", sp, 32'hFFFF_FFFF);
    m_sp   = 32'hFFFF_FFFF;
    mon_en = 1;

    // Normal operation after reset
    do_op(C_NONE, 1'b1, 16'h00AB, 16'h0, 16'h0, 3'd7, 0, 16'h0);
    go_idle();
    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("req_q_drained", req_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule
